// File: rtl/dport_sched.sv
// DisplayPort frame scheduler: line/frame strobes, DMA restart and stuffer reset sequencing.
// Timing config is shadowed at frame boundaries so mid-frame writes only affect the next frame.
module dport_sched #(
    parameter int RST_CYC  = 16,
    parameter int MIN_LINE = 64
) (
    input  logic        i_dpclk,
    input  logic        i_resetn,
    input  logic        i_en,
    input  logic        i_link_ok,
    input  logic [15:0] i_cfg_lineclk,
    input  logic [15:0] i_cfg_lines,
    input  logic [15:0] i_cfg_vact,
    input  logic [7:0]  i_cfg_dmalead,
    output logic        o_dphstart,
    output logic        o_dpvstart,
    output logic        o_dmastart,
    output logic        o_stuff_reset,
    output logic        o_vblank,
    output logic        o_running,
    output logic        o_err_cfg,
    output logic [15:0] o_frame_cnt
);
    typedef enum logic [1:0] {ST_OFF, ST_WAKE, ST_RUN, ST_DRAIN} state_t;

    localparam logic [15:0] RST_CYC_W  = 16'(RST_CYC);
    localparam logic [15:0] MIN_LINE_W = 16'(MIN_LINE);

    state_t      r_state, w_state_next;
    logic [15:0] r_hctr, r_vctr, r_wctr;
    logic [15:0] w_hctr_next, w_vctr_next, w_wctr_next;
    logic [15:0] r_s_lineclk, r_s_lines, r_s_vact;
    logic [7:0]  r_s_dmalead;
    logic [15:0] w_s_lineclk_next, w_s_lines_next, w_s_vact_next;
    logic [7:0]  w_s_dmalead_next;
    logic        r_dphstart, r_dpvstart, r_dmastart, r_stuff_reset, r_vblank, r_running, r_err_cfg;
    logic        w_dphstart_next, w_dpvstart_next, w_dmastart_next, w_stuff_reset_next;
    logic        w_vblank_next, w_running_next, w_err_cfg_next;
    logic [15:0] r_frame_cnt, w_frame_cnt_next;
    logic        w_cfg_legal, w_line_end, w_frame_end, w_shadow_load, w_err_set, w_active_next;
    logic [15:0] w_dma_hpos;

    assign w_cfg_legal = (i_cfg_lineclk >= MIN_LINE_W) && (i_cfg_vact != 16'd0) &&
                         (i_cfg_lines > i_cfg_vact);
    assign w_line_end  = (r_hctr == r_s_lineclk - 16'd1);
    assign w_frame_end = w_line_end && (r_vctr == r_s_lines - 16'd1);

    always_comb begin
        w_state_next  = r_state;
        w_hctr_next   = r_hctr;
        w_vctr_next   = r_vctr;
        w_wctr_next   = r_wctr;
        w_shadow_load = 1'b0;
        w_err_set     = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (i_en && i_link_ok) begin
                    if (w_cfg_legal) begin
                        w_state_next  = ST_WAKE;
                        w_wctr_next   = 16'd0;
                        w_shadow_load = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            ST_WAKE: begin
                if (r_wctr == RST_CYC_W + {8'd0, r_s_dmalead}) begin
                    w_state_next = ST_RUN;
                    w_hctr_next  = 16'd0;
                    w_vctr_next  = 16'd0;
                end else begin
                    w_wctr_next = r_wctr + 16'd1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (w_frame_end) begin
                    w_hctr_next = 16'd0;
                    w_vctr_next = 16'd0;
                    // A new frame starts only if enabled and the freshly sampled config is legal
                    if (i_en && w_cfg_legal) begin
                        w_state_next  = ST_RUN;
                        w_shadow_load = 1'b1;
                    end else begin
                        w_state_next = ST_OFF;
                        w_wctr_next  = 16'd0;
                        w_err_set    = i_en;
                    end
                end else begin
                    if (w_line_end) begin
                        w_hctr_next = 16'd0;
                        w_vctr_next = r_vctr + 16'd1;
                    end else begin
                        w_hctr_next = r_hctr + 16'd1;
                    end
                    w_state_next = i_en ? ST_RUN : ST_DRAIN;
                end
            end
            default: w_state_next = ST_OFF;
        endcase
        // Losing the link overrides everything outside OFF
        if (!i_link_ok && (r_state != ST_OFF)) begin
            w_state_next  = ST_OFF;
            w_hctr_next   = 16'd0;
            w_vctr_next   = 16'd0;
            w_wctr_next   = 16'd0;
            w_shadow_load = 1'b0;
            w_err_set     = 1'b0;
        end
    end

    assign w_s_lineclk_next = w_shadow_load ? i_cfg_lineclk : r_s_lineclk;
    assign w_s_lines_next   = w_shadow_load ? i_cfg_lines   : r_s_lines;
    assign w_s_vact_next    = w_shadow_load ? i_cfg_vact    : r_s_vact;
    assign w_s_dmalead_next = w_shadow_load ? i_cfg_dmalead : r_s_dmalead;

    // Lead longer than a line clamps the DMA restart to the start of the last line
    assign w_dma_hpos = ({8'd0, w_s_dmalead_next} >= w_s_lineclk_next) ? 16'd0 :
                        w_s_lineclk_next - 16'd1 - {8'd0, w_s_dmalead_next};

    assign w_active_next      = (w_state_next == ST_RUN) || (w_state_next == ST_DRAIN);
    assign w_dphstart_next    = w_active_next && (w_hctr_next == 16'd0);
    assign w_dpvstart_next    = (w_state_next == ST_RUN) && (w_hctr_next == 16'd0) &&
                                (w_vctr_next == 16'd0);
    assign w_dmastart_next    = ((w_state_next == ST_WAKE) && (w_wctr_next == RST_CYC_W)) ||
                                ((w_state_next == ST_RUN) && (w_hctr_next == w_dma_hpos) &&
                                 (w_vctr_next == w_s_lines_next - 16'd1));
    assign w_stuff_reset_next = (w_state_next == ST_OFF) ||
                                ((w_state_next == ST_WAKE) && (w_wctr_next < RST_CYC_W));
    assign w_vblank_next      = w_active_next && (w_vctr_next >= w_s_vact_next);
    assign w_running_next     = w_active_next;
    assign w_err_cfg_next     = w_err_set ? 1'b1 : (i_en ? r_err_cfg : 1'b0);
    assign w_frame_cnt_next   = r_frame_cnt + {15'd0, w_dpvstart_next};

    always_ff @(posedge i_dpclk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state       <= ST_OFF;
            r_hctr        <= 16'd0;
            r_vctr        <= 16'd0;
            r_wctr        <= 16'd0;
            r_s_lineclk   <= 16'd0;
            r_s_lines     <= 16'd0;
            r_s_vact      <= 16'd0;
            r_s_dmalead   <= 8'd0;
            r_dphstart    <= 1'b0;
            r_dpvstart    <= 1'b0;
            r_dmastart    <= 1'b0;
            r_stuff_reset <= 1'b1;
            r_vblank      <= 1'b0;
            r_running     <= 1'b0;
            r_err_cfg     <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_state       <= w_state_next;
            r_hctr        <= w_hctr_next;
            r_vctr        <= w_vctr_next;
            r_wctr        <= w_wctr_next;
            r_s_lineclk   <= w_s_lineclk_next;
            r_s_lines     <= w_s_lines_next;
            r_s_vact      <= w_s_vact_next;
            r_s_dmalead   <= w_s_dmalead_next;
            r_dphstart    <= w_dphstart_next;
            r_dpvstart    <= w_dpvstart_next;
            r_dmastart    <= w_dmastart_next;
            r_stuff_reset <= w_stuff_reset_next;
            r_vblank      <= w_vblank_next;
            r_running     <= w_running_next;
            r_err_cfg     <= w_err_cfg_next;
            r_frame_cnt   <= w_frame_cnt_next;
        end
    end

    assign o_dphstart    = r_dphstart;
    assign o_dpvstart    = r_dpvstart;
    assign o_dmastart    = r_dmastart;
    assign o_stuff_reset = r_stuff_reset;
    assign o_vblank      = r_vblank;
    assign o_running     = r_running;
    assign o_err_cfg     = r_err_cfg;
    assign o_frame_cnt   = r_frame_cnt;
endmodule
